// File: rtl/rpn_pkg.sv
// Shared types and sizes for the RPN stack sequencer slice.
package rpn_pkg;

  localparam int WIDTH   = 32;
  localparam int DEPTH   = 16;
  localparam int DEPTH_W = $clog2(DEPTH + 1);

  typedef enum logic [1:0] {
    ADD = 2'd0,
    SUB = 2'd1,
    XOR = 2'd2,
    OUT = 2'd3
  } op_t;

  typedef enum logic [2:0] {
    IDLE,
    PUSH,
    POP_B,
    WAIT_B,
    POP_A,
    WAIT_A,
    EXEC,
    RESULT
  } state_t;

endpackage

// File: rtl/rpn_stack_sequencer_if.sv
// Token handshake between a token producer (master) and the sequencer (slave).
interface rpn_stack_sequencer_if;
  import rpn_pkg::*;

  logic             tok_valid;
  logic             tok_ready;
  logic             tok_is_op;
  op_t              tok_op;
  logic [WIDTH-1:0] tok_data;

  modport master (output tok_valid, tok_is_op, tok_op, tok_data, input tok_ready);
  modport slave  (input tok_valid, tok_is_op, tok_op, tok_data, output tok_ready);
endinterface

// File: rtl/rpn_alu.sv
// Combinational operator unit: result = a op b, modulo 2^WIDTH.
module rpn_alu
  import rpn_pkg::*;
(
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  input  op_t              op,
  output logic [WIDTH-1:0] result
);

  // Operator select; OUT never reaches EXEC so its arm is a don't-care zero.
  always_comb begin
    // NOTE: every combinational output gets a default first so no path can infer a latch.
    result = '0;
    case (op)
      ADD:     result = a + b;
      SUB:     result = a - b;
      XOR:     result = a ^ b;
      default: result = '0;
    endcase
  end

endmodule

// File: rtl/rpn_stack_sequencer.sv
// RPN token sequencer driving an external 16x32 LIFO. Numbers are pushed,
// binary operators pop b then a and push a op b, OUT pops and reports the top.
module rpn_stack_sequencer
  import rpn_pkg::*;
(
  input  logic                 clk,
  input  logic                 rst_n,
  rpn_stack_sequencer_if.slave tok,
  input  logic                 err_clr,
  output logic                 err,
  output logic                 res_valid,
  output logic [WIDTH-1:0]     res_data,
  output logic                 stk_push,
  output logic                 stk_pop,
  output logic [WIDTH-1:0]     stk_din,
  input  logic [WIDTH-1:0]     stk_dout,
  input  logic                 stk_full
);

  state_t               state, state_d;
  op_t                  op_q;
  logic [DEPTH_W-1:0]   depth;
  logic [WIDTH-1:0]     a_q, b_q, din_q, alu_res;
  logic                 accept, err_set;

  // The LIFO's own full flag is observed but occupancy is tracked by depth.
  logic unused_stk_full;
  assign unused_stk_full = stk_full;

  rpn_alu u_alu (
    .a      (a_q),
    .b      (b_q),
    .op     (op_q),
    .result (alu_res)
  );

  // Output decode from registered state only; tok_ready never sees tok_valid.
  assign tok.tok_ready = (state == IDLE) && !err;
  assign accept        = tok.tok_valid && tok.tok_ready;
  assign stk_push      = (state == PUSH) || (state == EXEC);
  assign stk_pop       = (state == POP_B) || (state == POP_A);
  assign res_valid     = (state == RESULT);
  assign stk_din       = (state == EXEC) ? alu_res : din_q;

  // Next-state and error detection for the token sequence.
  always_comb begin
    state_d = state;
    err_set = 1'b0;
    case (state)
      IDLE: begin
        if (accept) begin
          if (!tok.tok_is_op) begin
            if (depth == DEPTH_W'(DEPTH)) err_set = 1'b1;
            else                          state_d = PUSH;
          end else if (tok.tok_op == OUT) begin
            if (depth == '0) err_set = 1'b1;
            else             state_d = POP_B;
          end else begin
            if (depth < DEPTH_W'(2)) err_set = 1'b1;
            else                     state_d = POP_B;
          end
        end
      end
      PUSH:    state_d = IDLE;
      POP_B:   state_d = WAIT_B;
      WAIT_B:  state_d = (op_q == OUT) ? RESULT : POP_A;
      POP_A:   state_d = WAIT_A;
      WAIT_A:  state_d = EXEC;
      EXEC:    state_d = IDLE;
      RESULT:  state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  // State register; reset abandons any sequence in flight.
  always_ff @(posedge clk or negedge rst_n) begin
    // NOTE: sequential state uses non-blocking assignments so every register samples pre-edge values.
    if (!rst_n) state <= IDLE;
    else        state <= state_d;
  end

  // Depth counter mirrors LIFO occupancy; push and pop are mutually exclusive by state.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n)        depth <= '0;
    else if (stk_push) depth <= depth + 1'b1;
    else if (stk_pop)  depth <= depth - 1'b1;
  end

  // Sticky error; a clear request takes priority over a coincident new error.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n)       err <= 1'b0;
    else if (err_clr) err <= 1'b0;
    else if (err_set) err <= 1'b1;
  end

  // Token capture, operand capture from the LIFO, and held OUT result.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      op_q     <= ADD;
      din_q    <= '0;
      a_q      <= '0;
      b_q      <= '0;
      res_data <= '0;
    end else begin
      if (accept) begin
        op_q <= tok.tok_op;
        if (!tok.tok_is_op) din_q <= tok.tok_data;
      end
      if (state == WAIT_B) begin
        b_q <= stk_dout;
        if (op_q == OUT) res_data <= stk_dout;
      end
      if (state == WAIT_A) a_q <= stk_dout;
    end
  end

endmodule

// File: doc/rpn_stack_sequencer.md
RPN_STACK_SEQUENCER -- requirements
Module: rpn_stack_sequencer

Interface
REQ-001 SHALL have one clock and an asynchronous, active-low reset.
REQ-002 SHALL provide these ports:
- clk  in  1  rising-edge clock
- rst_n  in  1  asynchronous active-low reset
- tok_valid  in  1  token offered
- tok_ready  out  1  token accepted when tok_valid&&tok_ready at a rising edge
- tok_is_op  in  1  0=number, 1=operator
- tok_op  in  2  0=ADD, 1=SUB, 2=XOR, 3=OUT
- tok_data  in  32  number operand
- err_clr  in  1  clears sticky error
- err  out  1  sticky underflow/overflow flag
- res_valid  out  1  one-cycle result strobe
- res_data  out  32  OUT result
- stk_push  out  1  push request to downstream 16x32 LIFO
- stk_pop  out  1  pop request to LIFO
- stk_din  out  32  push data
- stk_dout  in  32  LIFO pop data, valid the cycle after stk_pop
- stk_full  in  1  LIFO full flag, monitor only

Function
REQ-003 SHALL keep an internal depth counter of 0..16 that mirrors LIFO occupancy: +1 per stk_push and -1 per stk_pop.
REQ-004 SHALL use these FSM states: IDLE, PUSH, POP_B, WAIT_B, POP_A, WAIT_A, EXEC, RESULT.
REQ-005 SHALL drive tok_ready=1 only in IDLE with err=0.
REQ-006 Number accepted at edge k: state PUSH during cycle k+1, stk_push=1, stk_din=tok_data (registered at acceptance), depth+1, then IDLE.
REQ-007 ADD/SUB/XOR accepted at edge k:
- POP_B in cycle k+1 (stk_pop=1)
- WAIT_B in cycle k+2, capture b=stk_dout
- POP_A in cycle k+3 (stk_pop=1)
- WAIT_A in cycle k+4, capture a
- EXEC in cycle k+5: stk_push=1, stk_din=a op b
- IDLE in cycle k+6
REQ-008 OUT accepted at edge k:
- POP_B in cycle k+1
- WAIT_B in cycle k+2, capture b
- RESULT in cycle k+3: res_valid=1, res_data=b
- IDLE in cycle k+4
REQ-009 SUB SHALL compute a-b, where a was pushed earlier than b.
REQ-010 All arithmetic SHALL be 32-bit modulo 2^32, with no carry or overflow flag.
REQ-011 Number with depth==16: token consumed, no push, err set at the acceptance edge.
REQ-012 Binary operator with depth<2, or OUT with depth==0: token consumed, no pop, err set, depth unchanged.
REQ-013 stk_push and stk_pop SHALL never be asserted in the same cycle, and at most one SHALL be asserted per cycle.
REQ-014 err_clr SHALL clear err at the next edge.
REQ-015 If err_clr and an error condition coincide, err_clr wins.
REQ-016 tok_ready SHALL be decoded from registered state and err only, with no combinational path from tok_valid.
REQ-017 res_data SHALL hold its last value between strobes.
REQ-018 stk_full is informational only; depth governs overflow.

Reset
REQ-019 rst_n low SHALL immediately force:
- state=IDLE, depth=0
- err=0, res_valid=0, res_data=0
- stk_push=0, stk_pop=0, stk_din=0
- captured a/b=0
REQ-020 Reset mid-operation SHALL abandon the sequence, with no further stack requests; the LIFO is reset in the same reset domain.
REQ-021 After rst_n deasserts, tok_ready SHALL be 1 on the first cycle.

Structure
REQ-022 Package rpn_pkg SHALL hold WIDTH=32, DEPTH=16, the op_t enum (ADD, SUB, XOR, OUT) and the state_t enum.
REQ-023 Sub-module rpn_alu SHALL be combinational: a, b, op in, 32-bit result out.
REQ-024 The FSM, depth counter and operand registers SHALL stay in the top module.

Verification
REQ-025 Push 7, push 5, SUB -> stk_din=2 in EXEC; OUT -> res_valid one cycle with res_data=2; depth=0.
REQ-026 Push 0x00000001, push 0xFFFFFFFF, ADD -> result 0x00000000 (wrap).
REQ-027 16 number pushes, then a 17th -> no stk_push on the 17th, err=1, tok_ready=0; err_clr -> tok_ready=1 next cycle.
REQ-028 Empty: ADD -> err=1, no stk_pop; after err_clr, OUT with depth 0 -> err=1.
REQ-029 Push 3, push 9, XOR, with rst_n low in cycle k+3 -> no stk_push in subsequent cycles, depth=0, all outputs 0.
REQ-030 Back-to-back tokens with tok_valid held high -> tok_ready low during sequences; operator latency exactly 6 cycles from acceptance to next tok_ready.
